// File: rtl/fetch_pkg.sv
// fetch_pkg: shared widths and buffer entry type for the fetch stage
package fetch_pkg;
  localparam int XLEN = 32;
  localparam int INSTR_BYTES = 4;
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;
endpackage

// File: rtl/fetch_buffer.sv
// fetch_buffer: 2-entry FIFO of fetched {pc, instr} pairs with flush
module fetch_buffer
  import fetch_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  fetch_entry_t din,
  output fetch_entry_t head,
  output logic [1:0]   count
);
  fetch_entry_t e0, e1;
  assign head = e0;
  // e0 is always the head; entries shift forward on pop
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      e0 <= '0;
      e1 <= '0;
      count <= '0;
    end else if (flush) begin
      count <= '0;
    end else begin
      if (pop && count == 2'd2) e0 <= e1;
      else if (push && (pop || count == 2'd0)) e0 <= din;
      if (push && count == (pop ? 2'd2 : 2'd1)) e1 <= din;
      count <= count + 2'(push) - 2'(pop);
    end
  assert property (@(posedge clk) disable iff (!rst_n) !(push && !pop && !flush && count == 2'd2));
  assert property (@(posedge clk) disable iff (!rst_n) !(pop && count == 2'd0));
endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: PC, synchronous instruction memory and buffered valid/ready output to decode
module fetch_stage
  import fetch_pkg::*;
#(
  parameter int MEM_DEPTH = 1024,
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         load_en,
  input  logic [$clog2(MEM_DEPTH)-1:0] load_addr,
  input  logic [XLEN-1:0]              load_data,
  input  logic                         redirect_valid,
  input  logic [XLEN-1:0]              redirect_pc,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [XLEN-1:0]              out_instr,
  output logic [XLEN-1:0]              out_pc
);
  localparam int AW = $clog2(MEM_DEPTH);
  logic [XLEN-1:0] mem [MEM_DEPTH];
  logic [XLEN-1:0] fetch_pc, inflight_pc, rdata;
  logic inflight, pop, issue;
  logic [1:0] count;
  fetch_entry_t head, cap;
  assign out_valid = count != 2'd0;
  assign pop = out_valid & out_ready;
  // occupancy counts the in-flight read so the buffer can never overflow
  assign issue = !load_en && !redirect_valid &&
                 ({1'b0, count} + {2'b0, inflight} - {2'b0, pop} < 3'd2);
  assign cap = '{pc: inflight_pc, instr: rdata};
  assign out_instr = out_valid ? head.instr : '0;
  assign out_pc = out_valid ? head.pc : '0;
  always_ff @(posedge clk) begin
    if (load_en) mem[load_addr] <= load_data;
    if (issue) rdata <= mem[fetch_pc[AW+1:2]];
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      fetch_pc <= RESET_PC;
      inflight_pc <= '0;
      inflight <= 1'b0;
    end else begin
      inflight <= issue;
      if (issue) inflight_pc <= fetch_pc;
      fetch_pc <= redirect_valid ? (redirect_pc & ~32'h3) :
                  issue ? fetch_pc + XLEN'(INSTR_BYTES) : fetch_pc;
    end
  fetch_buffer u_buf (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (inflight & ~redirect_valid),
    .pop   (pop),
    .flush (redirect_valid),
    .din   (cap),
    .head  (head),
    .count (count)
  );
endmodule
